seven_segment_driver: RTL and testbench



---
 rtl/seven_segment_pkg.sv | 34 +++
 rtl/bin13_to_bcd.sv | 74 +++++++
 rtl/seven_segment_driver.sv | 109 ++++++++++
 tb/tb_seven_segment_driver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// ---------------------------------------------------------------------------
// seven_segment_pkg
// Shared definitions for the seven-segment display driver:
//   state_t       frame sequencer states
//   CONV_CYCLES   double-dabble iterations per 13-bit conversion
//   FRAME_BITS    serial bits per frame (4 digits x 8 segments)
//   SEG_CODES     segment patterns {dp,g,f,e,d,c,b,a} for digits 0..9
//   digit_to_seg  BCD digit to segment byte, 0x00 for codes 10..15
// ---------------------------------------------------------------------------
package seven_segment_pkg;

    typedef enum logic [1:0] {
        CAPTURE,
        CONVERT,
        SHIFT,
        LATCH
    } state_t;

    localparam int CONV_CYCLES = 13;
    localparam int FRAME_BITS  = 32;

    localparam logic [7:0] SEG_CODES [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    function automatic logic [7:0] digit_to_seg(input logic [3:0] digit);
        if (digit > 4'd9) begin
            return 8'h00;
        end
        return SEG_CODES[digit];
    endfunction

endpackage

// File: rtl/bin13_to_bcd.sv
// ---------------------------------------------------------------------------
// bin13_to_bcd
// Sequential double-dabble converter: 13-bit binary to four BCD digits in
// CONV_CYCLES clock cycles.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (control only)
//   start  load bin and clear the BCD accumulator; conversion begins next cycle
//   bin    13-bit unsigned value, sampled on start
//   bcd    {thousands, hundreds, tens, units}, valid once conversion ends
//   done   high during the cycle whose rising edge completes the last iteration
// ---------------------------------------------------------------------------
module bin13_to_bcd
    import seven_segment_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [12:0] bin,
    output logic [15:0] bcd,
    output logic        done
);

    logic [12:0] bin_q;
    logic [15:0] bcd_q;
    logic [3:0]  iter_cnt;
    logic        busy;

    // Add 3 to every nibble >= 5 so the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] value);
        logic [15:0] result;
        result = value;
        for (int i = 0; i < 4; i++) begin
            if (result[4*i +: 4] >= 4'd5) begin
                result[4*i +: 4] = result[4*i +: 4] + 4'd3;
            end
        end
        return result;
    endfunction

    logic [15:0] bcd_adj;
    assign bcd_adj = dabble_adjust(bcd_q);

    // Combinational so the sequencer can leave CONVERT on the same edge that
    // performs the final iteration.
    assign done = busy && (iter_cnt == 4'(CONV_CYCLES - 1));
    assign bcd  = bcd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            iter_cnt <= 4'd0;
        end else if (start) begin
            busy     <= 1'b1;
            iter_cnt <= 4'd0;
        end else if (busy) begin
            iter_cnt <= iter_cnt + 4'd1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            bin_q <= bin;
            bcd_q <= 16'd0;
        end else if (busy) begin
            {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
        end
    end

endmodule

// File: rtl/seven_segment_driver.sv
// ---------------------------------------------------------------------------
// seven_segment_driver
// Continuously refreshes a four-digit seven-segment display through an
// external 74HC595-style shift-register chain. Each 47-cycle frame captures
// i_Bin13, converts it to BCD, shifts 32 segment bits out MSB first
// (thousands digit first) and pulses the storage latch.
// Ports:
//   i_CLK       system clock (also the board-level shift clock)
//   i_RST       synchronous active-high reset; aborts the current frame
//   i_Bin13     13-bit unsigned value, sampled once per frame
//   o_SegData   registered serial segment data, 0 outside the shift phase
//   o_SegLatch  registered one-cycle latch pulse after the 32nd bit
// Build option:
//   SEVSEG_BLANK_LEADING_ZEROS_EN  blank leading zero digits (units always shown)
// ---------------------------------------------------------------------------
module seven_segment_driver
    import seven_segment_pkg::*;
(
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [12:0] i_Bin13,
    output logic        o_SegData,
    output logic        o_SegLatch
);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  bit_cnt;
    logic [31:0] shift_reg;
    logic [31:0] frame_word;
    logic [15:0] bcd;
    logic        conv_start;
    logic        conv_done;

    assign conv_start = (state == CAPTURE);

    bin13_to_bcd u_bin13_to_bcd (
        .clk   (i_CLK),
        .rst   (i_RST),
        .start (conv_start),
        .bin   (i_Bin13),
        .bcd   (bcd),
        .done  (conv_done)
    );

    logic [3:0] d3, d2, d1, d0;
    logic       blank3, blank2, blank1;

    assign {d3, d2, d1, d0} = bcd;

`ifdef SEVSEG_BLANK_LEADING_ZEROS_EN
    // Blanking propagates from the thousands digit down and stops at the
    // first nonzero digit; the units digit is never blanked.
    assign blank3 = (d3 == 4'd0);
    assign blank2 = blank3 && (d2 == 4'd0);
    assign blank1 = blank2 && (d1 == 4'd0);
`else
    assign blank3 = 1'b0;
    assign blank2 = 1'b0;
    assign blank1 = 1'b0;
`endif

    assign frame_word = {blank3 ? 8'h00 : digit_to_seg(d3),
                         blank2 ? 8'h00 : digit_to_seg(d2),
                         blank1 ? 8'h00 : digit_to_seg(d1),
                         digit_to_seg(d0)};

    always_comb begin
        state_nxt = state;
        case (state)
            CAPTURE: state_nxt = CONVERT;
            CONVERT: if (conv_done) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == 5'(FRAME_BITS - 1)) state_nxt = LATCH;
            LATCH:   state_nxt = CAPTURE;
            default: state_nxt = CAPTURE;
        endcase
    end

    // Outputs are registered from the current state, so they trail the
    // sequencer by one cycle: bit k appears 14+k cycles after capture and
    // the latch pulse 46 cycles after capture.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state      <= CAPTURE;
            bit_cnt    <= 5'd0;
            o_SegData  <= 1'b0;
            o_SegLatch <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= (state == SHIFT) ? bit_cnt + 5'd1 : 5'd0;
            o_SegLatch <= (state == LATCH);
            if (state == SHIFT) begin
                o_SegData <= (bit_cnt == 5'd0) ? frame_word[31] : shift_reg[31];
            end else begin
                o_SegData <= 1'b0;
            end
        end
    end

    // BCD is stable throughout SHIFT, so the frame is loaded on the first
    // shift cycle with its MSB already sent.
    always_ff @(posedge i_CLK) begin
        if (state == SHIFT) begin
            shift_reg <= (bit_cnt == 5'd0) ? {frame_word[30:0], 1'b0}
                                           : {shift_reg[30:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_seven_segment_driver.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_driver
// Directed testbench for seven_segment_driver. Frame timing is referenced to
// the capture edge; expected segment frames are hand-computed constants.
// Honors SEVSEG_BLANK_LEADING_ZEROS_EN for the blanked expectations.
// ---------------------------------------------------------------------------
module tb_seven_segment_driver;

    logic        i_CLK = 1'b0;
    logic        i_RST = 1'b1;
    logic [12:0] i_Bin13 = 13'd0;
    logic        o_SegData;
    logic        o_SegLatch;

    int checks = 0;
    int errors = 0;

    seven_segment_driver dut (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_Bin13    (i_Bin13),
        .o_SegData  (o_SegData),
        .o_SegLatch (o_SegLatch)
    );

    always #5 i_CLK = ~i_CLK;

    localparam logic [46:0] LATCH_MASK = 47'd1 << 46;
    localparam logic [46:0] SHIFT_MASK = {1'b0, {32{1'b1}}, 14'd0};

    // Value table and hand-computed frames {D3,D2,D1,D0}
    logic [12:0] vals [7] = '{13'd0, 13'd1, 13'd32, 13'd70, 13'd1005, 13'd4095, 13'd8191};
`ifdef SEVSEG_BLANK_LEADING_ZEROS_EN
    logic [31:0] exps [7] = '{32'h0000003F, 32'h00000006, 32'h00004F5B, 32'h0000073F,
                              32'h063F3F6D, 32'h663F6F6D, 32'h7F066F06};
    localparam logic [31:0] EXP_1  = 32'h00000006;
    localparam logic [31:0] EXP_32 = 32'h00004F5B;
`else
    logic [31:0] exps [7] = '{32'h3F3F3F3F, 32'h3F3F3F06, 32'h3F3F4F5B, 32'h3F3F073F,
                              32'h063F3F6D, 32'h663F6F6D, 32'h7F066F06};
    localparam logic [31:0] EXP_1  = 32'h3F3F3F06;
    localparam logic [31:0] EXP_32 = 32'h3F3F4F5B;
`endif

    logic [31:0] got_frame;
    logic [46:0] got_latch;
    logic [46:0] got_data;

    // Called at the negedge just before a capture edge; samples cycles 0..46
    // after that edge and returns at the negedge before the next capture.
    task automatic collect_frame(input int chg_at, input logic [12:0] chg_val);
        got_frame = 32'd0;
        got_latch = 47'd0;
        got_data  = 47'd0;
        for (int n = 0; n < 47; n++) begin
            @(posedge i_CLK);
            @(negedge i_CLK);
            got_latch[n] = o_SegLatch;
            got_data[n]  = o_SegData;
            if (n >= 14 && n <= 45) got_frame = {got_frame[30:0], o_SegData};
            if (n == chg_at) i_Bin13 = chg_val;
        end
    endtask

    task automatic do_reset(input logic [12:0] value);
        @(negedge i_CLK);
        i_RST = 1'b1;
        repeat (3) @(negedge i_CLK);
        i_Bin13 = value;
        i_RST = 1'b0;
    endtask

    task automatic test_reset;
        i_RST   = 1'b1;
        i_Bin13 = 13'd8191;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_CLK);
            checks++;
            if (o_SegData !== 1'b0 || o_SegLatch !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: data=%b latch=%b required 0 0", c, o_SegData, o_SegLatch);
            end
            checks++;
            if (dut.state !== seven_segment_pkg::CAPTURE) begin
                errors++;
                $display("FAIL reset_state cycle %0d: state=%0d required CAPTURE", c, dut.state);
            end
        end
        i_RST = 1'b0;
        collect_frame(-1, 13'd0);
        checks++;
        if (got_frame !== 32'h7F066F06) begin
            errors++;
            $display("FAIL first_frame_after_reset: got %h required %h", got_frame, 32'h7F066F06);
        end
        checks++;
        if (got_latch !== LATCH_MASK) begin
            errors++;
            $display("FAIL first_frame_latch: got %h required %h", got_latch, LATCH_MASK);
        end
    endtask

    task automatic test_frames;
        do_reset(vals[0]);
        for (int i = 0; i < 7; i++) begin
            i_Bin13 = vals[i];
            collect_frame(-1, 13'd0);
            checks++;
            if (got_frame !== exps[i]) begin
                errors++;
                $display("FAIL frame_bits value=%0d: got %h required %h", vals[i], got_frame, exps[i]);
            end
            checks++;
            if (got_latch !== LATCH_MASK) begin
                errors++;
                $display("FAIL frame_latch value=%0d: got %h required %h", vals[i], got_latch, LATCH_MASK);
            end
            checks++;
            if ((got_data & ~SHIFT_MASK) !== 47'd0) begin
                errors++;
                $display("FAIL data_outside_shift value=%0d: got %h required 0", vals[i], got_data & ~SHIFT_MASK);
            end
        end
    endtask

    task automatic test_back_to_back;
        do_reset(13'd1);
        collect_frame(20, 13'd32);
        checks++;
        if (got_frame !== EXP_1) begin
            errors++;
            $display("FAIL change_mid_shift_current: got %h required %h", got_frame, EXP_1);
        end
        collect_frame(-1, 13'd0);
        checks++;
        if (got_frame !== EXP_32) begin
            errors++;
            $display("FAIL change_mid_shift_next: got %h required %h", got_frame, EXP_32);
        end
        checks++;
        if (got_latch !== LATCH_MASK) begin
            errors++;
            $display("FAIL change_mid_shift_latch: got %h required %h", got_latch, LATCH_MASK);
        end
    endtask

    task automatic test_reset_mid_shift;
        do_reset(13'd1);
        for (int n = 0; n < 20; n++) begin
            @(posedge i_CLK);
            @(negedge i_CLK);
        end
        i_RST = 1'b1;
        @(posedge i_CLK);
        @(negedge i_CLK);
        checks++;
        if (o_SegData !== 1'b0 || o_SegLatch !== 1'b0) begin
            errors++;
            $display("FAIL mid_shift_reset_outputs: data=%b latch=%b required 0 0", o_SegData, o_SegLatch);
        end
        i_RST   = 1'b0;
        i_Bin13 = 13'd32;
        collect_frame(-1, 13'd0);
        checks++;
        if (got_latch !== LATCH_MASK) begin
            errors++;
            $display("FAIL aborted_frame_latch: got %h required %h", got_latch, LATCH_MASK);
        end
        checks++;
        if (got_frame !== EXP_32) begin
            errors++;
            $display("FAIL frame_after_abort: got %h required %h", got_frame, EXP_32);
        end
    endtask

    initial begin
        test_reset;
        test_frames;
        test_back_to_back;
        test_reset_mid_shift;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
